// File: rtl/llki_pkg.sv
// ----------------------------------------------------------------------------
// llki_pkg
//   Shared types and constants for the LLKI discrete key interface.
//   Imported by the discrete key sender (initiator) and its receive-side peer.
//
//   llki_op_e            : command opcode carried on cmd_op
//   llki_status_e        : per-command status returned on resp_status
//   llki_sender_state_e  : sender FSM state encoding
//   LLKI_MAX_KEY_WORDS   : largest legal key length in 64-bit words
//   LLKI_SENDER_TIMEOUT  : default idle-cycle budget per handshake step
// ----------------------------------------------------------------------------
package llki_pkg;

  localparam int unsigned LLKI_MAX_KEY_WORDS  = 32;
  localparam int unsigned LLKI_SENDER_TIMEOUT = 4096;

  typedef enum logic {
    LLKI_OP_LOAD  = 1'b0,
    LLKI_OP_CLEAR = 1'b1
  } llki_op_e;

  typedef enum logic [1:0] {
    LLKI_ST_OK         = 2'd0,
    LLKI_ST_BAD_LEN    = 2'd1,
    LLKI_ST_TIMEOUT    = 2'd2,
    LLKI_ST_EARLY_CMPL = 2'd3
  } llki_status_e;

  typedef enum logic [2:0] {
    SND_IDLE      = 3'd0,
    SND_FETCH     = 3'd1,
    SND_SEND      = 3'd2,
    SND_WAIT_CMPL = 3'd3,
    SND_CLEAR_REQ = 3'd4,
    SND_RESP      = 3'd5
  } llki_sender_state_e;

  // A key length is legal when it is non-zero and fits the key RAM.
  function automatic logic llki_len_ok(input int unsigned num_words,
                                       input int unsigned max_words);
    return (num_words != 0) && (num_words <= max_words);
  endfunction

endpackage : llki_pkg

// File: rtl/llki_discrete_key_sender.sv
// ----------------------------------------------------------------------------
// llki_discrete_key_sender
//   Initiator side of the LLKI discrete key interface. Accepts one LOAD or
//   CLEAR command at a time, streams key words read from a 1-cycle-latency
//   key RAM to the core over a valid/ready handshake (LOAD), or raises a
//   level clear request until acknowledged (CLEAR), and returns exactly one
//   status response per accepted command.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/ready       command handshake; cmd_ready only high in IDLE
//   cmd_op                LLKI_OP_LOAD / LLKI_OP_CLEAR
//   cmd_num_words         key length in 64-bit words for LOAD
//   key_rd_en/addr        key RAM read strobe and word address
//   key_rd_data           key RAM data, valid the cycle after key_rd_en
//   llkid_key_data/valid  key word to the core, held until llkid_key_ready
//   llkid_key_ready       core accepts the word on valid && ready
//   llkid_key_complete    core reports the full key is loaded
//   llkid_clear_key       clear request level, dropped when ack is sampled
//   llkid_clear_key_ack   core acknowledges the clear
//   resp_valid/ready      status handshake; status held until consumed
//   resp_status           llki_status_e code
// ----------------------------------------------------------------------------
module llki_discrete_key_sender
  import llki_pkg::*;
#(
  parameter int MAX_KEY_WORDS = int'(LLKI_MAX_KEY_WORDS),
  parameter int ADDR_W        = $clog2(MAX_KEY_WORDS),
  parameter int TIMEOUT_CYC   = int'(LLKI_SENDER_TIMEOUT)
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W:0]   cmd_num_words,

  output logic              key_rd_en,
  output logic [ADDR_W-1:0] key_rd_addr,
  input  logic [63:0]       key_rd_data,

  output logic [63:0]       llkid_key_data,
  output logic              llkid_key_valid,
  input  logic              llkid_key_ready,
  input  logic              llkid_key_complete,
  output logic              llkid_clear_key,
  input  logic              llkid_clear_key_ack,

  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_status
);

  // Counter is wide enough to hold TIMEOUT_CYC itself so it can saturate
  // there instead of wrapping back to zero.
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [ADDR_W:0]   ONE_LEN  = (ADDR_W + 1)'(1);

  llki_sender_state_e state;
  logic [ADDR_W:0]    num_words;
  logic [TMO_W-1:0]   tmo_cnt;

  logic         cmd_fire;
  logic         key_hs;
  logic         last_word;
  logic         tmo_hit;
  logic         len_ok;
  logic         done;
  llki_status_e done_status;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign key_hs    = llkid_key_valid && llkid_key_ready;
  // key_rd_addr doubles as the word index of the word currently in flight.
  assign last_word = ({1'b0, key_rd_addr} == (num_words - ONE_LEN));
  // The step times out on the cycle whose count completes TIMEOUT_CYC
  // idle cycles, so the guarded output is high for exactly TIMEOUT_CYC cycles.
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign len_ok    = llki_len_ok(32'(cmd_num_words), 32'(MAX_KEY_WORDS));

  // --------------------------------------------------------------------------
  // Termination decode: every path that ends a command and moves to RESP,
  // together with the status it reports. Priority inside SEND: a handshake
  // on the last word wins over everything (OK if complete arrives with it),
  // then an early complete, then the timeout.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    done        = 1'b0;
    done_status = LLKI_ST_OK;
    unique case (state)
      SND_IDLE: begin
        if (cmd_fire && (llki_op_e'(cmd_op) == LLKI_OP_LOAD) && !len_ok) begin
          done        = 1'b1;
          done_status = LLKI_ST_BAD_LEN;
        end
      end
      SND_FETCH: begin
        if (llkid_key_complete) begin
          done        = 1'b1;
          done_status = LLKI_ST_EARLY_CMPL;
        end
      end
      SND_SEND: begin
        if (key_hs && last_word) begin
          if (llkid_key_complete) begin
            done        = 1'b1;
            done_status = LLKI_ST_OK;
          end
        end else if (llkid_key_complete) begin
          done        = 1'b1;
          done_status = LLKI_ST_EARLY_CMPL;
        end else if (!key_hs && tmo_hit) begin
          done        = 1'b1;
          done_status = LLKI_ST_TIMEOUT;
        end
      end
      SND_WAIT_CMPL: begin
        if (llkid_key_complete) begin
          done        = 1'b1;
          done_status = LLKI_ST_OK;
        end else if (tmo_hit) begin
          done        = 1'b1;
          done_status = LLKI_ST_TIMEOUT;
        end
      end
      SND_CLEAR_REQ: begin
        if (llkid_clear_key_ack) begin
          done        = 1'b1;
          done_status = LLKI_ST_OK;
        end else if (tmo_hit) begin
          done        = 1'b1;
          done_status = LLKI_ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SND_IDLE;
      num_words       <= '0;
      tmo_cnt         <= '0;
      cmd_ready       <= 1'b0;
      key_rd_en       <= 1'b0;
      key_rd_addr     <= '0;
      llkid_key_data  <= '0;
      llkid_key_valid <= 1'b0;
      llkid_clear_key <= 1'b0;
      resp_valid      <= 1'b0;
      resp_status     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only; a later
      // assignment in this block overrides an earlier one, which is how the
      // per-transition counter clear below takes precedence over the count.
      if ((state inside {SND_SEND, SND_WAIT_CMPL, SND_CLEAR_REQ}) &&
          (tmo_cnt != TMO_MAX)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (done) begin
        // Any terminating path drops all LLKI traffic in the same edge.
        state           <= SND_RESP;
        tmo_cnt         <= '0;
        cmd_ready       <= 1'b0;
        key_rd_en       <= 1'b0;
        llkid_key_valid <= 1'b0;
        llkid_clear_key <= 1'b0;
        resp_valid      <= 1'b1;
        resp_status     <= done_status;
      end else begin
        unique case (state)
          SND_IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_fire) begin
              cmd_ready <= 1'b0;
              tmo_cnt   <= '0;
              if (llki_op_e'(cmd_op) == LLKI_OP_CLEAR) begin
                llkid_clear_key <= 1'b1;
                state           <= SND_CLEAR_REQ;
              end else begin
                // Illegal lengths were caught by the termination decode.
                num_words   <= cmd_num_words;
                key_rd_addr <= '0;
                key_rd_en   <= 1'b1;
                state       <= SND_FETCH;
              end
            end
          end

          // Two cycles: the first drives the read strobe, the second sees
          // the RAM data and captures it. key_rd_en tells them apart.
          SND_FETCH: begin
            key_rd_en <= 1'b0;
            if (!key_rd_en) begin
              llkid_key_data  <= key_rd_data;
              llkid_key_valid <= 1'b1;
              tmo_cnt         <= '0;
              state           <= SND_SEND;
            end
          end

          SND_SEND: begin
            if (key_hs) begin
              llkid_key_valid <= 1'b0;
              tmo_cnt         <= '0;
              if (last_word) begin
                state <= SND_WAIT_CMPL;
              end else begin
                key_rd_addr <= key_rd_addr + ADDR_W'(1);
                key_rd_en   <= 1'b1;
                state       <= SND_FETCH;
              end
            end
          end

          // Both waits only leave through the termination decode.
          SND_WAIT_CMPL: ;
          SND_CLEAR_REQ: ;

          SND_RESP: begin
            if (resp_ready) begin
              resp_valid <= 1'b0;
              cmd_ready  <= 1'b1;
              state      <= SND_IDLE;
            end
          end

          default: state <= SND_IDLE;
        endcase
      end
    end
  end

endmodule : llki_discrete_key_sender

// File: tb/tb_llki_discrete_key_sender.sv
// ----------------------------------------------------------------------------
// tb_llki_discrete_key_sender
//   Directed bench for the LLKI discrete key sender: key RAM model, a
//   configurable receiver (ready delay, complete pulse, clear ack delay),
//   and hand-computed expectations for each command scenario.
// ----------------------------------------------------------------------------
module tb_llki_discrete_key_sender;
  import llki_pkg::*;

  localparam int MAXW   = 32;
  localparam int AW     = 5;
  localparam int TMO    = 16;
  localparam logic [63:0] KEY_BASE = 64'hA5A5_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW:0]   cmd_num_words;
  logic          key_rd_en;
  logic [AW-1:0] key_rd_addr;
  logic [63:0]   key_rd_data = '0;
  logic [63:0]   llkid_key_data;
  logic          llkid_key_valid;
  logic          llkid_key_ready = 1'b0;
  logic          llkid_key_complete = 1'b0;
  logic          llkid_clear_key;
  logic          llkid_clear_key_ack = 1'b0;
  logic          resp_valid;
  logic          resp_ready;
  logic [1:0]    resp_status;

  always #5 clk = ~clk;

  llki_discrete_key_sender #(
    .MAX_KEY_WORDS (MAXW),
    .ADDR_W        (AW),
    .TIMEOUT_CYC   (TMO)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cmd_num_words       (cmd_num_words),
    .key_rd_en           (key_rd_en),
    .key_rd_addr         (key_rd_addr),
    .key_rd_data         (key_rd_data),
    .llkid_key_data      (llkid_key_data),
    .llkid_key_valid     (llkid_key_valid),
    .llkid_key_ready     (llkid_key_ready),
    .llkid_key_complete  (llkid_key_complete),
    .llkid_clear_key     (llkid_clear_key),
    .llkid_clear_key_ack (llkid_clear_key_ack),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_status         (resp_status)
  );

  // Key RAM: word i holds KEY_BASE + i, read data one cycle after strobe.
  logic [63:0] ram [MAXW];
  initial for (int i = 0; i < MAXW; i++) ram[i] = KEY_BASE + 64'(i);
  always @(posedge clk) if (key_rd_en) key_rd_data <= ram[key_rd_addr];

  // Monitors: everything the DUT does on its outputs, sampled at the edge.
  logic [63:0]   rx_log [$];
  logic [AW-1:0] rd_log [$];
  int rx_count = 0;
  int rd_cnt   = 0;
  int vld_cnt  = 0;
  int clr_cnt  = 0;
  always @(posedge clk) begin
    if (llkid_key_valid && llkid_key_ready) begin
      rx_log.push_back(llkid_key_data);
      rx_count <= rx_count + 1;
    end
    if (key_rd_en) begin
      rd_log.push_back(key_rd_addr);
      rd_cnt <= rd_cnt + 1;
    end
    if (llkid_key_valid) vld_cnt <= vld_cnt + 1;
    if (llkid_clear_key) clr_cnt <= clr_cnt + 1;
  end

  // Receiver model, driven on the falling edge.
  logic rx_en     = 1'b1;
  int   rx_delay  = 0;
  int   clr_delay = 7;
  int   cmpl_at   = -1;
  bit   cmpl_same = 1'b0;
  int   cmpl_fired = -1;
  int   wcnt = 0;
  int   ccnt = 0;
  always @(negedge clk) begin
    if (llkid_key_complete) llkid_key_complete = 1'b0;
    if (llkid_key_ready) begin
      llkid_key_ready = 1'b0;
      wcnt = 0;
    end else if (rx_en && llkid_key_valid) begin
      wcnt++;
      if (wcnt >= rx_delay) begin
        llkid_key_ready = 1'b1;
        if (cmpl_same && (rx_count + 1 == cmpl_at)) begin
          llkid_key_complete = 1'b1;
          cmpl_fired = cmpl_at;
        end
      end
    end else begin
      wcnt = 0;
    end
    if (!cmpl_same && (rx_count == cmpl_at) && (cmpl_fired != cmpl_at)) begin
      llkid_key_complete = 1'b1;
      cmpl_fired = cmpl_at;
    end
    if (llkid_clear_key) begin
      ccnt++;
      if (ccnt >= clr_delay) llkid_clear_key_ack = 1'b1;
    end else begin
      ccnt = 0;
      llkid_clear_key_ack = 1'b0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input string tag, input llki_op_e op,
                          input int n);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_num_words = (AW + 1)'(n);
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, " busy"}, 64'(cmd_ready), 64'd0);
  endtask

  task automatic wait_resp(input string tag, input llki_status_e exp);
    int k = 0;
    while (!resp_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    check({tag, " status"}, 64'(resp_status), 64'(exp));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " resp drop"}, 64'(resp_valid), 64'd0);
  endtask

  int base, rb, vb, cb, stable, k;

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 1'b0;
    cmd_num_words = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst cmd_ready",  64'(cmd_ready), 64'd0);
    check("rst rd_en",      64'(key_rd_en), 64'd0);
    check("rst key_valid",  64'(llkid_key_valid), 64'd0);
    check("rst clear_key",  64'(llkid_clear_key), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst key_data",   llkid_key_data, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle cmd_ready", 64'(cmd_ready), 64'd1);

    // 1) LOAD 5, receiver ready after 2 cycles, complete after last word.
    rx_delay = 2;
    base = rx_count;
    cmpl_at = base + 5;
    send_cmd("t1", LLKI_OP_LOAD, 5);
    wait_resp("t1", LLKI_ST_OK);
    check("t1 words", 64'(rx_count - base), 64'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t1 word%0d", i), rx_log[base + i], KEY_BASE + 64'(i));

    // 2) Illegal lengths: 0 and MAX+1.
    rb = rd_cnt;
    vb = vld_cnt;
    send_cmd("t2a", LLKI_OP_LOAD, 0);
    wait_resp("t2a", LLKI_ST_BAD_LEN);
    send_cmd("t2b", LLKI_OP_LOAD, MAXW + 1);
    wait_resp("t2b", LLKI_ST_BAD_LEN);
    check("t2 no rd_en", 64'(rd_cnt - rb), 64'd0);
    check("t2 no valid", 64'(vld_cnt - vb), 64'd0);

    // 3) CLEAR acked after 7 cycles.
    cb = clr_cnt;
    clr_delay = 7;
    send_cmd("t3", LLKI_OP_CLEAR, 0);
    wait_resp("t3", LLKI_ST_OK);
    check("t3 clear cycles", 64'(clr_cnt - cb), 64'd7);
    check("t3 clear low", 64'(llkid_clear_key), 64'd0);

    // 4) LOAD 3 with receiver never ready -> timeout after 16 cycles.
    rx_en = 1'b0;
    cmpl_at = -1;
    base = rx_count;
    vb = vld_cnt;
    send_cmd("t4", LLKI_OP_LOAD, 3);
    wait_resp("t4", LLKI_ST_TIMEOUT);
    check("t4 valid cycles", 64'(vld_cnt - vb), 64'd16);
    check("t4 no words", 64'(rx_count - base), 64'd0);
    check("t4 valid low", 64'(llkid_key_valid), 64'd0);
    rx_en = 1'b1;

    // 5) LOAD 4, complete pulsed after word 2 -> early complete.
    rx_delay = 0;
    base = rx_count;
    cmpl_at = base + 2;
    send_cmd("t5", LLKI_OP_LOAD, 4);
    wait_resp("t5", LLKI_ST_EARLY_CMPL);
    repeat (5) @(negedge clk);
    check("t5 words", 64'(rx_count - base), 64'd2);

    // Last word handshake with complete in the same cycle -> OK at once.
    base = rx_count;
    cmpl_same = 1'b1;
    cmpl_at = base + 1;
    send_cmd("tpri", LLKI_OP_LOAD, 1);
    wait_resp("tpri", LLKI_ST_OK);
    cmpl_same = 1'b0;
    check("tpri words", 64'(rx_count - base), 64'd1);

    // Longest legal key.
    base = rx_count;
    cmpl_at = base + MAXW;
    send_cmd("tmax", LLKI_OP_LOAD, MAXW);
    wait_resp("tmax", LLKI_ST_OK);
    check("tmax words", 64'(rx_count - base), 64'(MAXW));
    check("tmax last", rx_log[base + MAXW - 1], KEY_BASE + 64'(MAXW - 1));

    // 6) Reset while word 2 is being offered, then a fresh LOAD 2.
    rx_delay = 5;
    cmpl_at = -1;
    base = rx_count;
    send_cmd("t6a", LLKI_OP_LOAD, 3);
    k = 0;
    while (!((rx_count - base == 1) && llkid_key_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t6 in word2", 64'(llkid_key_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6 rst valid",     64'(llkid_key_valid), 64'd0);
    check("t6 rst data",      llkid_key_data, 64'd0);
    check("t6 rst rd_en",     64'(key_rd_en), 64'd0);
    check("t6 rst cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rb = rd_log.size();
    base = rx_count;
    rx_delay = 0;
    cmpl_at = base + 2;
    send_cmd("t6b", LLKI_OP_LOAD, 2);
    wait_resp("t6b", LLKI_ST_OK);
    check("t6 first addr", 64'(rd_log[rb]), 64'd0);
    check("t6 word0", rx_log[base], KEY_BASE);
    check("t6 word1", rx_log[base + 1], KEY_BASE + 64'd1);

    // Response stalled for 10 cycles: status held, no new command taken.
    send_cmd("tst", LLKI_OP_LOAD, 0);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid && (resp_status == LLKI_ST_BAD_LEN) && !cmd_ready)
        stable++;
    end
    check("tst stable", 64'(stable), 64'd10);
    wait_resp("tst", LLKI_ST_BAD_LEN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_llki_discrete_key_sender
